mat_core: RTL and testbench

- Single processing core of the tensor-native processor: fetches 32-bit instructions from a private instruction memory and executes vector float operations on a small vector register file backed by a private float data memory.
- Exchanges SWITCH_WIDTH-element float vectors with peer cores over a send/receive switch interface.
- Raises done after executing HALT.
- Simulation-level model: all float storage and arithmetic is shortreal (IEEE single).

---
 rtl/mat_core.sv | 224 ++++++++++++++++++++++
 tb/tb_mat_core.sv | 346 ++++++++++++++++++++++++++++++++++
 2 files changed

// File: rtl/mat_core.sv
// mat_core: one tensor-processor core. It fetches from a private instruction memory
// and runs vector float ops on a 4-entry register file. A blocking send/recv switch port links it to peer cores.

module mat_inst_mem #(
    parameter int SIZE = 65536,
    parameter int AW   = $clog2(SIZE)
) (
    input  logic [AW-1:0] addr,
    output logic [31:0]   rdata
);
    // Preloaded hierarchically; never cleared by reset.
    logic [31:0] inst_mem [0:SIZE-1];

    assign rdata = inst_mem[addr];
endmodule

module mat_data_mem #(
    parameter int SIZE = 65536,
    parameter int W    = 16,
    parameter int AW   = $clog2(SIZE)
) (
    input  logic     clock,
    input  logic [15:0] base,
    input  logic     we,
    input  shortreal wdata [W],
    output shortreal rdata [W]
);
    shortreal      data_mem [0:SIZE-1];
    logic [AW-1:0] addr [W];

    // Vector element k lives at base+k, wrapping around the end of memory.
    always_comb begin
        for (int k = 0; k < W; k++) begin
            addr[k]  = AW'((32'(base) + 32'(k)) % 32'(SIZE));
            rdata[k] = data_mem[addr[k]];
        end
    end

    always_ff @(posedge clock) begin
        if (we) begin
            for (int k = 0; k < W; k++) begin
                data_mem[addr[k]] <= wdata[k];
            end
        end
    end
endmodule

module mat_core #(
    parameter int SWITCH_CORE_SIZE      = 4,
    parameter int SWITCH_WIDTH          = 16,
    parameter int INST_MEM_SIZE         = 65536,
    parameter int DATA_MEM_SIZE         = 65536,
    parameter int SWITCH_CORE_ADDR_SIZE = $clog2(SWITCH_CORE_SIZE)
) (
    input  logic                             clock,
    input  logic                             reset,
    output logic                             done,
    output logic                             switch_send_ready,
    output logic [SWITCH_CORE_ADDR_SIZE-1:0] switch_send_core_idx,
    output shortreal                         switch_send_data [SWITCH_WIDTH],
    input  logic                             switch_send_ok,
    output logic                             switch_recv_request,
    output logic [SWITCH_CORE_ADDR_SIZE-1:0] switch_recv_core_idx,
    input  logic                             switch_recv_ready,
    input  shortreal                         switch_recv_data [SWITCH_WIDTH]
);
    localparam int IA = $clog2(INST_MEM_SIZE);

    localparam logic [3:0] OP_LOADV  = 4'd1;
    localparam logic [3:0] OP_STOREV = 4'd2;
    localparam logic [3:0] OP_VADD   = 4'd3;
    localparam logic [3:0] OP_VMUL   = 4'd4;
    localparam logic [3:0] OP_VMAC   = 4'd5;
    localparam logic [3:0] OP_DOT    = 4'd6;
    localparam logic [3:0] OP_SEND   = 4'd7;
    localparam logic [3:0] OP_RECV   = 4'd8;
    localparam logic [3:0] OP_HALT   = 4'd15;

    typedef enum logic [1:0] {S_RUN, S_SEND, S_RECV, S_HALTED} state_t;

    state_t      state_q, state_d;
    logic [15:0] pc, pc_next;
    logic [31:0] instr;
    logic [3:0]  opcode;
    logic [1:0]  rd, rs1, rs2;
    logic [15:0] imm;
    logic        unused_instr_bits;

    shortreal vreg   [4][SWITCH_WIDTH];
    shortreal src_a  [SWITCH_WIDTH];
    shortreal src_b  [SWITCH_WIDTH];
    shortreal mem_rd [SWITCH_WIDTH];
    shortreal wb_vec [SWITCH_WIDTH];
    shortreal dot_acc;
    logic     wb_en, mem_we, retire;

    assign opcode            = instr[31:28];
    assign rd                = instr[27:26];
    assign rs1               = instr[25:24];
    assign rs2               = instr[23:22];
    assign imm               = instr[15:0];
    assign unused_instr_bits = ^instr[21:16];
    assign pc_next           = 16'((32'(pc) + 32'd1) % 32'(INST_MEM_SIZE));

    mat_inst_mem #(.SIZE(INST_MEM_SIZE)) inst_mem (
        .addr  (pc[IA-1:0]),
        .rdata (instr)
    );

    mat_data_mem #(.SIZE(DATA_MEM_SIZE), .W(SWITCH_WIDTH)) data_mem (
        .clock (clock),
        .base  (imm),
        .we    (mem_we && !reset),
        .wdata (src_a),
        .rdata (mem_rd)
    );

    always_ff @(posedge clock) begin
        if (reset) state_q <= S_RUN;
        else       state_q <= state_d;
    end

    // Next state plus datapath controls; sources are read before any write-back.
    always_comb begin
        state_d = state_q;
        wb_en   = 1'b0;
        mem_we  = 1'b0;
        retire  = 1'b0;
        dot_acc = 0.0;
        for (int k = 0; k < SWITCH_WIDTH; k++) begin
            src_a[k]  = vreg[rs1][k];
            src_b[k]  = vreg[rs2][k];
            wb_vec[k] = 0.0;
        end
        for (int k = 0; k < SWITCH_WIDTH; k++) begin
            dot_acc = dot_acc + src_a[k] * src_b[k];
        end

        unique case (state_q)
            S_RUN: begin
                case (opcode)
                    OP_LOADV: begin
                        wb_en  = 1'b1;
                        retire = 1'b1;
                        for (int k = 0; k < SWITCH_WIDTH; k++) wb_vec[k] = mem_rd[k];
                    end
                    OP_STOREV: begin
                        mem_we = 1'b1;
                        retire = 1'b1;
                    end
                    OP_VADD: begin
                        wb_en  = 1'b1;
                        retire = 1'b1;
                        for (int k = 0; k < SWITCH_WIDTH; k++) wb_vec[k] = src_a[k] + src_b[k];
                    end
                    OP_VMUL: begin
                        wb_en  = 1'b1;
                        retire = 1'b1;
                        for (int k = 0; k < SWITCH_WIDTH; k++) wb_vec[k] = src_a[k] * src_b[k];
                    end
                    OP_VMAC: begin
                        wb_en  = 1'b1;
                        retire = 1'b1;
                        for (int k = 0; k < SWITCH_WIDTH; k++)
                            wb_vec[k] = vreg[rd][k] + src_a[k] * src_b[k];
                    end
                    OP_DOT: begin
                        wb_en     = 1'b1;
                        retire    = 1'b1;
                        wb_vec[0] = dot_acc;
                    end
                    OP_SEND: state_d = S_SEND;
                    OP_RECV: state_d = S_RECV;
                    OP_HALT: state_d = S_HALTED;
                    default: retire = 1'b1;
                endcase
            end
            S_SEND: begin
                if (switch_send_ok) begin
                    retire  = 1'b1;
                    state_d = S_RUN;
                end
            end
            S_RECV: begin
                if (switch_recv_ready) begin
                    retire  = 1'b1;
                    wb_en   = 1'b1;
                    state_d = S_RUN;
                    for (int k = 0; k < SWITCH_WIDTH; k++) wb_vec[k] = switch_recv_data[k];
                end
            end
            S_HALTED: begin
            end
        endcase
    end

    // Handshake outputs are registered: they follow the state being entered.
    always_ff @(posedge clock) begin
        if (reset) begin
            pc                   <= '0;
            done                 <= 1'b0;
            switch_send_ready    <= 1'b0;
            switch_recv_request  <= 1'b0;
            switch_send_core_idx <= '0;
            switch_recv_core_idx <= '0;
            for (int k = 0; k < SWITCH_WIDTH; k++) switch_send_data[k] <= 0.0;
            for (int r = 0; r < 4; r++)
                for (int k = 0; k < SWITCH_WIDTH; k++) vreg[r][k] <= 0.0;
        end else begin
            if (retire) pc <= pc_next;
            if (wb_en)
                for (int k = 0; k < SWITCH_WIDTH; k++) vreg[rd][k] <= wb_vec[k];
            switch_send_ready   <= (state_d == S_SEND);
            switch_recv_request <= (state_d == S_RECV);
            done                <= (state_d == S_HALTED);
            if (state_q == S_RUN && opcode == OP_SEND) begin
                switch_send_core_idx <= imm[SWITCH_CORE_ADDR_SIZE-1:0];
                for (int k = 0; k < SWITCH_WIDTH; k++) switch_send_data[k] <= src_a[k];
            end
            if (state_q == S_RUN && opcode == OP_RECV)
                switch_recv_core_idx <= imm[SWITCH_CORE_ADDR_SIZE-1:0];
        end
    end
endmodule

// File: tb/tb_mat_core.sv
// Directed bench for mat_core: small programs are preloaded, expectations queued,
// and a monitor compares memory results and switch traffic as the core presents them.

module tb_mat_core;
    localparam int SW = 16;
    localparam int CA = 2;
    localparam int K_MEM = 0, K_SIDX = 1, K_SDATA = 2, K_SLEN = 3, K_SSTAB = 4, K_RIDX = 5, K_RLEN = 6;

    logic          clk = 1'b0;
    logic          reset = 1'b1;
    logic          done, send_ready, recv_request;
    logic          send_ok = 1'b0, recv_ready = 1'b0;
    logic [CA-1:0] send_idx, recv_idx;
    shortreal      send_data [SW];
    shortreal      recv_data [SW];

    mat_core dut (
        .clock                (clk),
        .reset                (reset),
        .done                 (done),
        .switch_send_ready    (send_ready),
        .switch_send_core_idx (send_idx),
        .switch_send_data     (send_data),
        .switch_send_ok       (send_ok),
        .switch_recv_request  (recv_request),
        .switch_recv_core_idx (recv_idx),
        .switch_recv_ready    (recv_ready),
        .switch_recv_data     (recv_data)
    );

    always #5 clk = ~clk;

    // Scoreboard
    logic [63:0] exp_q[$];
    int          kind_q[$];
    int          addr_q[$];
    int          n_cmp = 0, n_err = 0;

    task automatic check(input string name, input int idx, input logic [63:0] act,
                         input logic [63:0] exp, input bit is_real);
        n_cmp++;
        if (act !== exp) begin
            n_err++;
            if (is_real) $display("FAIL %s[%0d]: got %f required %f", name, idx, $bitstoreal(act), $bitstoreal(exp));
            else         $display("FAIL %s[%0d]: got %0d required %0d", name, idx, act, exp);
        end
    endtask

    task automatic push(input int kind, input int addr, input logic [63:0] exp);
        kind_q.push_back(kind);
        addr_q.push_back(addr);
        exp_q.push_back(exp);
    endtask

    task automatic push_mem(input int addr, input real v);
        push(K_MEM, addr, $realtobits(v));
    endtask

    task automatic push_send(input int idx, input real base, input real step, input int len);
        push(K_SIDX, 0, 64'(idx));
        for (int k = 0; k < SW; k++) push(K_SDATA, k, $realtobits(base + step * k));
        push(K_SLEN, 0, 64'(len));
        push(K_SSTAB, 0, 64'd0);
    endtask

    task automatic pop_check(input int kind, input string name, input int idx,
                             input logic [63:0] act, input bit is_real);
        logic [63:0] e;
        if (kind_q.size() == 0 || kind_q[0] != kind) begin
            n_cmp++;
            n_err++;
            $display("FAIL unexpected_%s[%0d]: got %0h with nothing of that kind queued", name, idx, act);
            return;
        end
        void'(kind_q.pop_front());
        void'(addr_q.pop_front());
        e = exp_q.pop_front();
        check(name, idx, act, e, is_real);
    endtask

    // Monitor
    bit            done_p = 0, send_p = 0, recv_p = 0, unstable = 0;
    int            send_len = 0, recv_len = 0, mon_addr;
    shortreal      snap [SW];
    logic [CA-1:0] snap_idx;

    initial begin : monitor
        forever begin
            @(negedge clk);
            if (done && !done_p) begin
                while (kind_q.size() > 0 && kind_q[0] == K_MEM) begin
                    mon_addr = addr_q[0];
                    pop_check(K_MEM, "mem", mon_addr, $realtobits(real'(dut.data_mem.data_mem[16'(mon_addr)])), 1);
                end
            end
            if (send_ready) begin
                if (!send_p) begin
                    send_len = 0;
                    unstable = 0;
                    snap_idx = send_idx;
                    for (int k = 0; k < SW; k++) snap[k] = send_data[k];
                    pop_check(K_SIDX, "send_idx", 0, 64'(send_idx), 0);
                    for (int k = 0; k < SW; k++)
                        pop_check(K_SDATA, "send_data", k, $realtobits(real'(send_data[k])), 1);
                end else begin
                    if (send_idx != snap_idx) unstable = 1;
                    for (int k = 0; k < SW; k++) if (send_data[k] != snap[k]) unstable = 1;
                end
                send_len++;
            end else if (send_p) begin
                pop_check(K_SLEN, "send_ready_cycles", 0, 64'(send_len), 0);
                pop_check(K_SSTAB, "send_unstable", 0, 64'(unstable), 0);
            end
            if (recv_request) begin
                if (!recv_p) begin
                    recv_len = 0;
                    pop_check(K_RIDX, "recv_idx", 0, 64'(recv_idx), 0);
                end
                recv_len++;
            end else if (recv_p) begin
                pop_check(K_RLEN, "recv_request_cycles", 0, 64'(recv_len), 0);
            end
            done_p = done;
            send_p = send_ready;
            recv_p = recv_request;
        end
    end

    // Driver tasks
    function automatic logic [31:0] enc(input logic [3:0] op, input logic [1:0] rd, input logic [1:0] rs1,
                                        input logic [1:0] rs2, input logic [15:0] imm);
        return {op, rd, rs1, rs2, 6'b0, imm};
    endfunction

    task automatic load_prog(input logic [31:0] p[$]);
        for (int i = 0; i < p.size(); i++) dut.inst_mem.inst_mem[16'(i)] = p[i];
    endtask

    task automatic set_mem(input int addr, input real v);
        dut.data_mem.data_mem[16'(addr % 65536)] = v;
    endtask

    task automatic begin_test();
        reset      = 1'b1;
        send_ok    = 1'b0;
        recv_ready = 1'b0;
        @(posedge clk);
        #1;
    endtask

    task automatic release_reset();
        repeat (2) @(posedge clk);
        #1 reset = 1'b0;
    endtask

    task automatic wait_done(input string name, input int budget, output int cycles);
        cycles = 0;
        while (!done && cycles < budget) begin
            @(posedge clk);
            #1;
            cycles++;
        end
        if (!done) begin
            n_cmp++;
            n_err++;
            $display("FAIL %s_timeout: done=%0b after %0d cycles, required 1", name, done, cycles);
        end
        repeat (2) @(posedge clk);
        #1;
    endtask

    task automatic wait_high(input string name, input int which, input int budget);
        int c = 0;
        while (((which == 0) ? !send_ready : !recv_request) && c < budget) begin
            @(posedge clk);
            #1;
            c++;
        end
        if (c >= budget) begin
            n_cmp++;
            n_err++;
            $display("FAIL %s_timeout: request low after %0d cycles, required 1", name, c);
        end
    endtask

    initial begin : watchdog
        #400000;
        $display("FAIL watchdog: simulation time limit reached, required completion");
        $fatal(1, "watchdog");
    end

    logic [31:0] prog[$];
    int          cyc;

    initial begin : stimulus
        for (int k = 0; k < SW; k++) recv_data[k] = 9.0;

        // Copy, plus reset state
        begin_test();
        check("rst_done", 0, 64'(done), 64'd0, 0);
        check("rst_send_ready", 0, 64'(send_ready), 64'd0, 0);
        check("rst_recv_request", 0, 64'(recv_request), 64'd0, 0);
        check("rst_send_idx", 0, 64'(send_idx), 64'd0, 0);
        check("rst_recv_idx", 0, 64'(recv_idx), 64'd0, 0);
        check("rst_send_data", 0, $realtobits(real'(send_data[0])), $realtobits(0.0), 1);
        check("rst_pc", 0, 64'(dut.pc), 64'd0, 0);
        prog = '{enc(1, 0, 0, 0, 0), enc(2, 0, 0, 0, 100), enc(15, 0, 0, 0, 0)};
        load_prog(prog);
        for (int i = 0; i < SW; i++) begin
            set_mem(i, i);
            set_mem(100 + i, -1.0);
            push_mem(100 + i, i);
        end
        release_reset();
        wait_done("copy", 50, cyc);
        n_cmp++;
        if (cyc > 4) begin
            n_err++;
            $display("FAIL copy_done_latency: got %0d cycles required at most 4", cyc);
        end

        // Arithmetic with an aliased VMUL v0,v0,v0
        begin_test();
        prog = '{enc(1, 0, 0, 0, 200), enc(1, 1, 0, 0, 216), enc(3, 2, 0, 1, 0), enc(4, 3, 0, 1, 0),
                 enc(5, 3, 0, 1, 0), enc(4, 0, 0, 0, 0), enc(2, 0, 2, 0, 300), enc(2, 0, 3, 0, 316),
                 enc(2, 0, 0, 0, 332), enc(15, 0, 0, 0, 0)};
        load_prog(prog);
        for (int i = 0; i < SW; i++) begin
            set_mem(200 + i, 1.5);
            set_mem(216 + i, 2.0);
            set_mem(300 + i, -1.0);
            set_mem(316 + i, -1.0);
            set_mem(332 + i, -1.0);
            push_mem(300 + i, 3.5);
            push_mem(316 + i, 6.0);
            push_mem(332 + i, 2.25);
        end
        release_reset();
        wait_done("arith", 50, cyc);

        // DOT, and registers cleared by reset (v3 held 6.0 before)
        begin_test();
        prog = '{enc(2, 0, 3, 0, 950), enc(1, 0, 0, 0, 400), enc(1, 1, 0, 0, 416), enc(1, 2, 0, 0, 400),
                 enc(6, 2, 0, 1, 0), enc(2, 0, 2, 0, 500), enc(15, 0, 0, 0, 0)};
        load_prog(prog);
        for (int i = 0; i < SW; i++) begin
            set_mem(400 + i, i + 1);
            set_mem(416 + i, 1.0);
            set_mem(500 + i, -1.0);
            set_mem(950 + i, -1.0);
            push_mem(950 + i, 0.0);
            push_mem(500 + i, (i == 0) ? 136.0 : 0.0);
        end
        release_reset();
        wait_done("dot", 50, cyc);

        // Address wrap on load and store
        begin_test();
        prog = '{enc(1, 1, 0, 0, 16'd65528), enc(2, 0, 1, 0, 600), enc(2, 0, 1, 0, 16'd65534), enc(15, 0, 0, 0, 0)};
        load_prog(prog);
        for (int i = 0; i < SW; i++) begin
            set_mem(65528 + i, 50.0 + i);
            set_mem(600 + i, -1.0);
            push_mem(600 + i, 50.0 + i);
        end
        for (int i = 0; i < SW; i++) push_mem((65534 + i) % 65536, 50.0 + i);
        release_reset();
        wait_done("wrap", 50, cyc);

        // SEND with send_ok held low for 5 wait cycles
        begin_test();
        prog = '{enc(1, 0, 0, 0, 400), enc(7, 0, 0, 0, 2), enc(2, 0, 0, 0, 700), enc(15, 0, 0, 0, 0)};
        load_prog(prog);
        for (int i = 0; i < SW; i++) begin
            set_mem(400 + i, i + 1);
            set_mem(700 + i, -1.0);
        end
        push_send(2, 1.0, 1.0, 6);
        for (int i = 0; i < SW; i++) push_mem(700 + i, i + 1);
        release_reset();
        wait_high("send", 0, 20);
        repeat (5) @(posedge clk);
        #1;
        check("send_pc_stalled", 0, 64'(dut.pc), 64'd1, 0);
        send_ok = 1'b1;
        @(posedge clk);
        #1 send_ok = 1'b0;
        wait_done("send", 50, cyc);

        // RECV with recv_ready pulsed in the third wait cycle
        begin_test();
        prog = '{enc(8, 2, 0, 0, 3), enc(2, 0, 2, 0, 800), enc(15, 0, 0, 0, 0)};
        load_prog(prog);
        for (int i = 0; i < SW; i++) set_mem(800 + i, -1.0);
        push(K_RIDX, 0, 64'd3);
        push(K_RLEN, 0, 64'd3);
        for (int i = 0; i < SW; i++) push_mem(800 + i, 7.0);
        release_reset();
        wait_high("recv", 1, 20);
        repeat (2) @(posedge clk);
        #1;
        recv_ready = 1'b1;
        for (int k = 0; k < SW; k++) recv_data[k] = 7.0;
        @(posedge clk);
        #1;
        recv_ready = 1'b0;
        for (int k = 0; k < SW; k++) recv_data[k] = 9.0;
        wait_done("recv", 50, cyc);

        // Reset during a SEND wait
        begin_test();
        prog = '{enc(1, 0, 0, 0, 400), enc(7, 0, 0, 0, 1), enc(15, 0, 0, 0, 0)};
        load_prog(prog);
        push_send(1, 1.0, 1.0, 3);
        release_reset();
        wait_high("send_rst", 0, 20);
        repeat (2) @(posedge clk);
        #1;
        reset = 1'b1;
        dut.inst_mem.inst_mem[0] = enc(15, 0, 0, 0, 0);
        @(posedge clk);
        #1;
        check("midrst_send_ready", 0, 64'(send_ready), 64'd0, 0);
        check("midrst_pc", 0, 64'(dut.pc), 64'd0, 0);
        check("midrst_done", 0, 64'(done), 64'd0, 0);
        release_reset();
        wait_done("midrst", 50, cyc);

        // Halted core ignores switch inputs
        send_ok    = 1'b1;
        recv_ready = 1'b1;
        repeat (4) @(posedge clk);
        #1;
        send_ok    = 1'b0;
        recv_ready = 1'b0;
        check("halt_done", 0, 64'(done), 64'd1, 0);
        check("halt_send_ready", 0, 64'(send_ready), 64'd0, 0);
        check("halt_recv_request", 0, 64'(recv_request), 64'd0, 0);
        check("halt_pc", 0, 64'(dut.pc), 64'd0, 0);

        repeat (2) @(posedge clk);
        check("leftover_expectations", 0, 64'(kind_q.size()), 64'd0, 0);
        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
        $finish;
    end
endmodule
